seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the driving end of the single-bit serial stream that our sequence detectors consume.
- Loads a pattern word of programmable length and shifts it out MSB-first, one bit per clock.
- Repeats the frame a programmed number of times, with configurable idle gaps between frames.
- Used as the stimulus source on the detector's serial input, in benches and in loopback self-test.

Parameters:
- MAX_LEN, 16: maximum pattern length in bits.
- LEN_W, 5: width of the length input; must hold MAX_LEN.
- REP_W, 4: width of the repeat-count input.
- GAP_LEN, 2: idle cycles inserted between repeated frames; 0 gives back-to-back frames.
- IDLE_BIT, 1'b0: value driven on x whenever no frame bit is being sent.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; block held in reset while 0.
- load  input  1  start request; sampled only in IDLE.
- pattern  input  MAX_LEN  bits to send; pattern[length-1] is sent first, pattern[0] last.
- length  input  LEN_W  number of valid pattern bits, legal range 1..MAX_LEN.
- repeat_cnt  input  REP_W  extra repetitions; total frames sent = repeat_cnt+1.
- abort  input  1  synchronous cancel of the current transfer.
- x  output  1  serial data bit.
- x_valid  output  1  x carries a frame bit this cycle.
- frame_start  output  1  one-cycle pulse coincident with the first bit of each frame.
- busy  output  1  high from the first bit of frame 0 through the last bit of the final frame, including gaps.
- done  output  1  one-cycle pulse coincident with the last bit of the final frame.
- err  output  1  one-cycle pulse when a load is rejected for an illegal length.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, x=IDLE_BIT, and x_valid, frame_start, busy, done, err all 0; internal registers cleared.
- All outputs are registered.
- State machine states: IDLE, SEND, GAP.
- IDLE:
  - load=1 with length in 1..MAX_LEN: capture pattern, length and repeat_cnt; go to SEND.
  - The next cycle (latency 1) drives x=pattern[length-1] with x_valid=1, frame_start=1, busy=1.
  - load=1 with length=0 or length>MAX_LEN: no capture, stay in IDLE, err=1 next cycle.
- SEND:
  - Bit index counts down from length-1 to 0, one bit per cycle.
  - On the bit-0 cycle with frames remaining, go to GAP if GAP_LEN>0; otherwise the next cycle starts the next frame directly, with frame_start=1.
  - On the bit-0 cycle of the final frame: done=1 in that same cycle; x_valid, busy and done drop the next cycle and state returns to IDLE.
- GAP:
  - Lasts exactly GAP_LEN cycles with x=IDLE_BIT, x_valid=0, busy=1.
  - The cycle after the gap ends carries the first bit of the next frame, with frame_start=1.
  - The frame counter decrements at each frame boundary; it never wraps, and repeat_cnt=2^REP_W-1 sends 2^REP_W frames.
- load while SEND or GAP: ignored; captured values stay unchanged and err is not raised.
- abort=1 in SEND or GAP: the next cycle is IDLE with x=IDLE_BIT and x_valid, busy, done, frame_start all 0. done is never pulsed for an aborted transfer.
- abort in IDLE: no effect. abort and load in the same IDLE cycle: abort wins, load dropped.
- Back-to-back transfers: the earliest accepted load is in the cycle after done. Its first bit appears 2 cycles after the done cycle, so there is one idle cycle between transfers.
- Reset asserted mid-transfer: immediate return to reset values; no done.
- length=1: a frame is a single cycle; frame_start and the last-bit condition coincide, and on the final frame frame_start and done are high together.

Decomposition:
- Shared package seq_pkg holds:
  - the state encoding constants (IDLE=2'd0, SEND=2'd1, GAP=2'd2);
  - the default MAX_LEN, LEN_W and REP_W values;
  - the 4-bit "0110" test pattern constant shared with the detector benches.
- No sub-module: the FSM, bit counter, gap counter and frame counter all live in one module.

Test Plan:
- Pattern 4'b0110, length 4, repeat_cnt 0; load in cycle 0 -> x=0,1,1,0 in cycles 1-4 with x_valid=1. frame_start in cycle 1, done in cycle 4, busy in cycles 1-4, idle from cycle 5.
- Same pattern, repeat_cnt 2, GAP_LEN 2 -> three frames, starting in cycles 1, 7 and 13 with frame_start each time. x=IDLE_BIT and x_valid=0 in cycles 5-6 and 11-12. done only in cycle 16.
- length 0, then length 17 (MAX_LEN 16) -> err pulse the cycle after each load; busy stays 0; x stays IDLE_BIT.
- Abort in the 3rd bit cycle of a length-8 send -> next cycle x_valid=0 and busy=0, done never asserted. A new load in the following cycle is accepted normally.
- Reset driven low asynchronously mid-frame, between clock edges -> all outputs go to reset values immediately. After reset release the block accepts a load with latency 1.
- length=1, pattern bit 1, repeat_cnt 1, GAP_LEN 0 -> x=1 in cycles 1 and 2, frame_start in both cycles, done in cycle 2 only.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence
// detector benches that consume its stream.
package seq_pkg;

  localparam int SEQ_MAX_LEN = 16;
  localparam int SEQ_LEN_W   = 5;
  localparam int SEQ_REP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // The "0110" pattern that the detector benches look for.
  localparam logic [3:0] SEQ_TEST_PAT = 4'b0110;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, one
// bit per clock, repeating the frame with optional idle gaps in between.
// Every output comes straight from a register.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int   MAX_LEN  = SEQ_MAX_LEN,
  parameter int   LEN_W    = SEQ_LEN_W,
  parameter int   REP_W    = SEQ_REP_W,
  parameter int   GAP_LEN  = 2,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [REP_W-1:0]   repeat_cnt,
  input  logic               abort,
  output logic               x,
  output logic               x_valid,
  output logic               frame_start,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [IDX_W-1:0]   r_top;     // index of the first bit of a frame (length-1)
  logic [IDX_W-1:0]   r_idx;     // index of the bit currently on x
  logic [REP_W-1:0]   r_frames;  // frames still to send after the current one
  logic [GAP_W-1:0]   r_gap;     // gap cycles remaining after the current one
  logic               r_x;
  logic               r_x_valid;
  logic               r_frame_start;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_len_ok;
  logic [IDX_W-1:0]   w_load_top;
  logic [IDX_W-1:0]   w_idx_dn;
  logic               w_last_bit;
  logic               w_more;
  logic               w_next_final;

  assign w_len_ok     = (length != '0) && (length <= LEN_W'(MAX_LEN));
  assign w_load_top   = IDX_W'(length - LEN_W'(1));
  assign w_idx_dn     = r_idx - IDX_W'(1);
  assign w_last_bit   = (r_idx == '0);
  assign w_more       = (r_frames != '0);
  // The frame about to start is the last one when exactly one remains.
  assign w_next_final = (r_frames == REP_W'(1));

  // Transfer FSM with bit, gap and frame counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_pat         <= '0;
      r_top         <= '0;
      r_idx         <= '0;
      r_frames      <= '0;
      r_gap         <= '0;
      r_x           <= IDLE_BIT;
      r_x_valid     <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // abort in the same cycle drops the load entirely
          if (load && !abort) begin
            if (w_len_ok) begin
              r_pat         <= pattern;
              r_top         <= w_load_top;
              r_idx         <= w_load_top;
              r_frames      <= repeat_cnt;
              r_x           <= pattern[w_load_top];
              r_x_valid     <= 1'b1;
              r_frame_start <= 1'b1;
              r_busy        <= 1'b1;
              r_done        <= (w_load_top == '0) && (repeat_cnt == '0);
              r_state       <= ST_SEND;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
          end else if (!w_last_bit) begin
            r_idx  <= w_idx_dn;
            r_x    <= r_pat[w_idx_dn];
            r_done <= (w_idx_dn == '0) && !w_more;
          end else if (!w_more) begin
            r_state   <= ST_IDLE;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
          end else if (GAP_LEN > 0) begin
            r_state   <= ST_GAP;
            r_gap     <= GAP_W'(GAP_LEN - 1);
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
          end else begin
            r_state       <= ST_SEND;
            r_frames      <= r_frames - REP_W'(1);
            r_idx         <= r_top;
            r_x           <= r_pat[r_top];
            r_frame_start <= 1'b1;
            r_done        <= (r_top == '0) && w_next_final;
          end
        end
        ST_GAP: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_gap == '0) begin
            r_state       <= ST_SEND;
            r_frames      <= r_frames - REP_W'(1);
            r_idx         <= r_top;
            r_x           <= r_pat[r_top];
            r_x_valid     <= 1'b1;
            r_frame_start <= 1'b1;
            r_done        <= (r_top == '0) && w_next_final;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_x       <= IDLE_BIT;
          r_x_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign x           = r_x;
  assign x_valid     = r_x_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one instance with a 2-cycle gap, one with
// back-to-back frames, compared cycle by cycle against an expected trace.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int   MAX_LEN  = 16;
  localparam int   LEN_W    = 5;
  localparam int   REP_W    = 4;
  localparam logic IDLE_BIT = 1'b0;

  typedef logic [5:0] vec_t;  // {x, x_valid, frame_start, busy, done, err}
  localparam vec_t IDLE_V = {IDLE_BIT, 5'b00000};
  localparam vec_t ERR_V  = {IDLE_BIT, 5'b00001};

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               abort = 1'b0;
  logic               load_a = 1'b0;
  logic               load_b = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   length = '0;
  logic [REP_W-1:0]   repeat_cnt = '0;

  logic x_a, xv_a, fs_a, busy_a, done_a, err_a;
  logic x_b, xv_b, fs_b, busy_b, done_b, err_b;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t exp_q[$];

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W),
                   .GAP_LEN(2), .IDLE_BIT(IDLE_BIT)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .pattern(pattern),
    .length(length), .repeat_cnt(repeat_cnt), .abort(abort),
    .x(x_a), .x_valid(xv_a), .frame_start(fs_a), .busy(busy_a),
    .done(done_a), .err(err_a));

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W),
                   .GAP_LEN(0), .IDLE_BIT(IDLE_BIT)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .pattern(pattern),
    .length(length), .repeat_cnt(repeat_cnt), .abort(abort),
    .x(x_b), .x_valid(xv_b), .frame_start(fs_b), .busy(busy_b),
    .done(done_b), .err(err_b));

  always #5 clk = ~clk;

  function automatic vec_t obs(input bit sel);
    return sel ? {x_b, xv_b, fs_b, busy_b, done_b, err_b}
               : {x_a, xv_a, fs_a, busy_a, done_a, err_a};
  endfunction

  task automatic check(input string tag, input vec_t got, input vec_t want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $display("FAIL %s got x/vld/fs/busy/done/err=%b want=%b t=%0t", tag, got, want, $time);
      $error("check %s differs", tag);
    end
  endtask

  // Expected per-cycle trace of one full transfer, from the cycle after load.
  task automatic build_expect(input logic [MAX_LEN-1:0] pat, input int len,
                              input int rep, input int gap);
    exp_q.delete();
    for (int f = 0; f <= rep; f++) begin
      for (int b = len - 1; b >= 0; b--)
        exp_q.push_back({pat[b], 1'b1, (b == len - 1), 1'b1, (f == rep) && (b == 0), 1'b0});
      if (f < rep)
        for (int g = 0; g < gap; g++)
          exp_q.push_back({IDLE_BIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_xfer(input bit sel, input logic [MAX_LEN-1:0] pat, input int len,
                          input int rep, input int abort_at, input int inject_at,
                          input string tag);
    int gap = sel ? 0 : 2;
    int n;
    build_expect(pat, len, rep, gap);
    n = exp_q.size();
    pattern = pat;
    length = LEN_W'(len);
    repeat_cnt = REP_W'(rep);
    if (sel) load_b = 1'b1; else load_a = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      abort = 1'b0;
      pattern = MAX_LEN'($urandom);
      length = LEN_W'($urandom);
      repeat_cnt = REP_W'($urandom);
      check(tag, obs(sel), exp_q[k-1]);
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check({tag, "/abort"}, obs(sel), IDLE_V);
        return;
      end
      if (k == inject_at) begin
        if (sel) load_b = 1'b1; else load_a = 1'b1;
      end
    end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
    check({tag, "/end"}, obs(sel), IDLE_V);
  endtask

  task automatic bad_len(input bit sel, input int len, input string tag);
    length = LEN_W'(len);
    if (sel) load_b = 1'b1; else load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
    check(tag, obs(sel), ERR_V);
    @(negedge clk);
    check({tag, "/after"}, obs(sel), IDLE_V);
  endtask

  initial begin
    logic [MAX_LEN-1:0] pat0110;
    pat0110 = {{(MAX_LEN-4){1'b0}}, SEQ_TEST_PAT};

    // reset state
    @(negedge clk);
    check("reset_a", obs(1'b0), IDLE_V);
    check("reset_b", obs(1'b1), IDLE_V);
    reset = 1'b1;
    @(negedge clk);
    check("idle_a", obs(1'b0), IDLE_V);

    // single frame, then three frames with gaps loaded back-to-back
    run_xfer(1'b0, pat0110, 4, 0, 0, 0, "p0110_r0");
    run_xfer(1'b0, pat0110, 4, 2, 0, 2, "p0110_r2");

    // illegal lengths
    bad_len(1'b0, 0, "len0");
    bad_len(1'b0, 17, "len17");
    bad_len(1'b1, 31, "len31_b");

    // abort and load together in IDLE: load dropped
    length = LEN_W'(4);
    load_a = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    abort = 1'b0;
    check("abort_load_idle", obs(1'b0), IDLE_V);
    @(negedge clk);
    check("abort_load_idle2", obs(1'b0), IDLE_V);

    // abort in the 3rd bit of a length-8 frame, then an immediate new load
    run_xfer(1'b0, MAX_LEN'($urandom), 8, 0, 3, 0, "abort8");
    run_xfer(1'b0, MAX_LEN'($urandom), 5, 1, 0, 0, "after_abort");

    // single-bit frames, no gap
    run_xfer(1'b1, MAX_LEN'(1), 1, 1, 0, 0, "len1_b");
    // maximum repeat count gives 16 frames
    run_xfer(1'b1, MAX_LEN'(2), 2, 15, 0, 0, "rep15_b");
    run_xfer(1'b0, 16'hA5C3, 16, 1, 0, 5, "len16_a");

    // asynchronous reset mid-frame
    pattern = 16'h00F0;
    length = LEN_W'(8);
    repeat_cnt = REP_W'(1);
    load_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      load_a = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("async_reset_a", obs(1'b0), IDLE_V);
    check("async_reset_b", obs(1'b1), IDLE_V);
    @(negedge clk);
    check("held_reset_a", obs(1'b0), IDLE_V);
    reset = 1'b1;
    run_xfer(1'b0, pat0110, 4, 0, 0, 0, "post_reset");

    // randomized transfers
    for (int t = 0; t < 24; t++) begin
      bit   sel;
      int   len, rep, n, ab, inj, idle;
      sel = 1'($urandom_range(0, 1));
      len = $urandom_range(1, MAX_LEN);
      rep = $urandom_range(0, 3);
      n = (rep + 1) * len + rep * (sel ? 0 : 2);
      ab = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      run_xfer(sel, MAX_LEN'($urandom), len, rep, ab, inj, "rand");
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        check("rand_idle", obs(sel), IDLE_V);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
